at_skid_latch: RTL and testbench



---
 rtl/at_skid_latch.sv | 101 ++++++++++
 tb/tb_at_skid_latch.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/at_skid_latch.sv
`default_nettype none
// ============================================================================
// at_skid_latch : two-entry registered skid/hold stage with load enable,
// flush and optional empty pass-through (macro AT_SKID_LATCH_BYPASS_EN).
// Rev 1.0
// ============================================================================
module at_skid_latch #(
  parameter int              SIZE      = 8,
  parameter logic [SIZE-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            reset_l,
  input  logic            en,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [SIZE-1:0] in_data,
  output logic            in_rdy,
  output logic            out_valid,
  output logic [SIZE-1:0] out_data,
  input  logic            out_rdy,
  output logic [1:0]      occ
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_t;

  state_t          state;
  logic [SIZE-1:0] main_q;
  logic [SIZE-1:0] skid_q;
  logic            main_v;
  logic            skid_v;
  logic            in_xfer;
  logic            out_xfer;
  logic            empty_load;

  assign main_v   = state[0];
  assign skid_v   = state[1];
  // reset_l gating keeps in_rdy low while reset is held yet lets the first edge after release capture
  assign in_rdy   = en & ~skid_v & reset_l;
  assign in_xfer  = in_valid & in_rdy;
  assign out_xfer = main_v & out_rdy;
  assign occ      = {1'b0, main_v} + {1'b0, skid_v};

`ifdef AT_SKID_LATCH_BYPASS_EN
  logic pass_sel;
  assign pass_sel   = ~main_v & in_valid & reset_l;
  assign out_valid  = main_v | (pass_sel & en);
  assign out_data   = pass_sel ? in_data : main_q;
  // a word that leaves the same cycle it arrives is never stored
  assign empty_load = in_xfer & ~out_rdy;
`else
  assign out_valid  = main_v;
  assign out_data   = main_q;
  assign empty_load = in_xfer;
`endif

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state  <= EMPTY;
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else if (flush) begin
      state  <= EMPTY;
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      case (state)
        EMPTY: begin
          if (empty_load) begin
            main_q <= in_data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (in_xfer) begin
            if (out_xfer) begin
              main_q <= in_data;
            end else begin
              skid_q <= in_data;
              state  <= TWO;
            end
          end else if (out_xfer) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_at_skid_latch.sv
`default_nettype none
// tb_at_skid_latch : scenario and randomized checks against a queue model.
module tb_at_skid_latch;

  logic       clk;
  logic       reset_l;
  logic       en;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_rdy;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_rdy;
  logic [1:0] occ;

  int passed = 0;
  int total  = 0;

  logic [7:0] mq[$];

  at_skid_latch #(.SIZE(8), .RESET_VAL(8'h00)) dut (
    .clk      (clk),
    .reset_l  (reset_l),
    .en       (en),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_rdy   (in_rdy),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_rdy  (out_rdy),
    .occ      (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected values derived from the FIFO contents and current inputs
  function automatic logic exp_valid();
    if (mq.size() > 0) return 1'b1;
`ifdef AT_SKID_LATCH_BYPASS_EN
    return in_valid & en & reset_l;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] exp_data();
    if (mq.size() > 0) return mq[0];
    return in_data;
  endfunction

  function automatic logic exp_rdy();
    return reset_l && en && (mq.size() < 2);
  endfunction

  function automatic logic [1:0] exp_occ();
    return 2'(mq.size());
  endfunction

  task automatic model_edge();
    bit ix;
    bit pass;
    ix   = in_valid && exp_rdy();
    pass = 1'b0;
    if (!reset_l || flush) begin
      mq.delete();
    end else begin
`ifdef AT_SKID_LATCH_BYPASS_EN
      pass = (mq.size() == 0) && ix && out_rdy;
`endif
      if (mq.size() > 0 && out_rdy) void'(mq.pop_front());
      if (ix && !pass) mq.push_back(in_data);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic e,
                       input logic r, input logic f);
    in_valid = v;
    in_data  = d;
    en       = e;
    out_rdy  = r;
    flush    = f;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset_l = 1'b0;
    drive(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b0 || in_rdy !== 1'b0 || occ !== 2'd0 || out_data !== 8'h00)
      $display("FAIL reset_init: v=%b rdy=%b occ=%0d data=%h, want 0 0 0 00", out_valid, in_rdy, occ, out_data);
    else passed++;
    tick();
    reset_l = 1'b1;
    drive(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
    tick();
    total++;
    if (occ !== 2'd2) $display("FAIL reset_fill: occ=%0d want 2", occ);
    else passed++;
    reset_l = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_rdy !== 1'b0 || occ !== 2'd0 || out_data !== 8'h00)
      $display("FAIL reset_async: v=%b rdy=%b occ=%0d data=%h, want 0 0 0 00", out_valid, in_rdy, occ, out_data);
    else passed++;
    tick();
    reset_l = 1'b1;
    drive(1'b1, 8'h44, 1'b1, 1'b0, 1'b0);
    total++;
    if (in_rdy !== 1'b1) $display("FAIL reset_release_rdy: rdy=%b want 1", in_rdy);
    else passed++;
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h44)
      $display("FAIL reset_first_capture: v=%b data=%h want 1 44", out_valid, out_data);
    else passed++;
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 8'(i), 1'b1, 1'b1, 1'b0);
`ifdef AT_SKID_LATCH_BYPASS_EN
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'(i) || occ !== 2'd0)
        $display("FAIL stream_bypass: v=%b data=%h occ=%0d want 1 %h 0", out_valid, out_data, occ, 8'(i));
      else passed++;
`else
      if (i > 1) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'(i - 1) || occ !== 2'd1)
          $display("FAIL stream: v=%b data=%h occ=%0d want 1 %h 1", out_valid, out_data, occ, 8'(i - 1));
        else passed++;
      end
`endif
      tick();
    end
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
`ifndef AT_SKID_LATCH_BYPASS_EN
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h10)
      $display("FAIL stream_last: v=%b data=%h want 1 10", out_valid, out_data);
    else passed++;
`endif
    tick();
  endtask

  task automatic test_stall();
    drive(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    total++;
    if (occ !== 2'd2 || in_rdy !== 1'b0 || out_data !== 8'hA5)
      $display("FAIL stall_full: occ=%0d rdy=%b data=%h want 2 0 a5", occ, in_rdy, out_data);
    else passed++;
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5)
      $display("FAIL stall_drain1: v=%b data=%h want 1 a5", out_valid, out_data);
    else passed++;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A || in_rdy !== 1'b1 || occ !== 2'd1)
      $display("FAIL stall_drain2: v=%b data=%h rdy=%b occ=%0d want 1 5a 1 1", out_valid, out_data, in_rdy, occ);
    else passed++;
    tick();
    total++;
    if (out_valid !== 1'b0 || occ !== 2'd0)
      $display("FAIL stall_empty: v=%b occ=%0d want 0 0", out_valid, occ);
    else passed++;
  endtask

  task automatic test_enable();
    drive(1'b1, 8'h61, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    total++;
    if (in_rdy !== 1'b0) $display("FAIL enable_rdy: rdy=%b want 0", in_rdy);
    else passed++;
    tick();
    tick();
    total++;
    if (occ !== 2'd1 || out_data !== 8'h61)
      $display("FAIL enable_hold: occ=%0d data=%h want 1 61", occ, out_data);
    else passed++;
    drive(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
    tick();
    total++;
    if (occ !== 2'd0 || out_valid !== 1'b0)
      $display("FAIL enable_drain: occ=%0d v=%b want 0 0", occ, out_valid);
    else passed++;
    tick();
    total++;
    if (occ !== 2'd0 || out_valid !== 1'b0)
      $display("FAIL enable_nocapture: occ=%0d v=%b want 0 0", occ, out_valid);
    else passed++;
  endtask

  task automatic test_flush();
    drive(1'b1, 8'h81, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h82, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h99, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    total++;
    if (occ !== 2'd0 || out_valid !== 1'b0 || out_data !== 8'h00)
      $display("FAIL flush: occ=%0d v=%b data=%h want 0 0 00", occ, out_valid, out_data);
    else passed++;
    tick();
  endtask

  task automatic test_bypass();
    drive(1'b1, 8'h7E, 1'b1, 1'b1, 1'b0);
`ifdef AT_SKID_LATCH_BYPASS_EN
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h7E || occ !== 2'd0)
      $display("FAIL bypass_same: v=%b data=%h occ=%0d want 1 7e 0", out_valid, out_data, occ);
    else passed++;
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    total++;
    if (out_valid !== 1'b0 || occ !== 2'd0)
      $display("FAIL bypass_after: v=%b occ=%0d want 0 0", out_valid, occ);
    else passed++;
`else
    total++;
    if (out_valid !== 1'b0) $display("FAIL latency_same: v=%b want 0", out_valid);
    else passed++;
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h7E)
      $display("FAIL latency_next: v=%b data=%h want 1 7e", out_valid, out_data);
    else passed++;
`endif
    tick();
  endtask

  task automatic test_random();
    logic       v;
    logic [7:0] d;
    for (int n = 0; n < 400; n++) begin
      v = 1'($urandom_range(0, 1));
      d = v ? 8'($urandom) : 8'hxx;
      drive(v, d, $urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)),
            $urandom_range(0, 31) == 0);
      total++;
      if (out_valid !== exp_valid() || in_rdy !== exp_rdy() || occ !== exp_occ() ||
          (exp_valid() && out_data !== exp_data()))
        $display("FAIL random[%0d]: v=%b rdy=%b occ=%0d data=%h want %b %b %0d %h",
                 n, out_valid, in_rdy, occ, out_data, exp_valid(), exp_rdy(), exp_occ(), exp_data());
      else passed++;
      tick();
    end
  endtask

  initial begin
    reset_l  = 1'b0;
    en       = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    out_rdy  = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_enable();
    test_flush();
    test_bypass();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
